// File: rtl/conway_engine.sv
// Conway's Game of Life engine: holds a WIDTH x HEIGHT board and steps it one
// generation per RUN cycle until the requested count is reached or the board settles.
module conway_engine #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int WRAP   = 0,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [WIDTH*HEIGHT-1:0]   load_states,
   input  logic                      start_valid,
   input  logic [GEN_W-1:0]          start_count,
   output logic                      busy,
   output logic                      done,
   output logic [WIDTH*HEIGHT-1:0]   out_states,
   output logic [GEN_W-1:0]          generation,
   output logic                      stable,
   output logic                      extinct
);

   localparam logic [GEN_W-1:0] ONE = {{(GEN_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                     state;
   state_t                     state_next;
   logic [GEN_W-1:0]           remaining;
   logic [WIDTH*HEIGHT-1:0]    next_board;
   logic                       settled;

   // Off-grid neighbours are either dead or folded back onto the torus.
   function automatic logic next_cell(input logic [WIDTH*HEIGHT-1:0] b,
                                      input int r, input int c);
      logic [3:0] sum;
      int         rr;
      int         cc;
      sum = 4'd0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (WRAP != 0) begin
               rr = (rr + HEIGHT) % HEIGHT;
               cc = (cc + WIDTH) % WIDTH;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH) begin
               sum = sum + {3'b000, b[rr*WIDTH+cc]};
            end
         end
      end
      return (sum == 4'd3) || (b[r*WIDTH+c] && (sum == 4'd2));
   endfunction

   always_comb begin
      next_board = '0;
      for (int r = 0; r < HEIGHT; r++) begin
         for (int c = 0; c < WIDTH; c++) begin
            next_board[r*WIDTH+c] = next_cell(out_states, r, c);
         end
      end
   end

   assign settled    = (next_board == out_states);
   assign load_ready = (state == IDLE);
   assign busy       = (state == RUN);
   assign extinct    = (out_states == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!load_valid && start_valid && start_count != '0) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (settled || remaining == ONE) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A zero-length start completes immediately, so done is raised straight from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_states <= '0;
         generation <= '0;
         remaining  <= '0;
         done       <= 1'b0;
         stable     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  out_states <= load_states;
                  generation <= '0;
                  stable     <= 1'b0;
               end else if (start_valid) begin
                  stable <= 1'b0;
                  if (start_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     remaining <= start_count;
                  end
               end
            end
            RUN: begin
               if (settled) begin
                  stable <= 1'b1;
                  done   <= 1'b1;
               end else begin
                  out_states <= next_board;
                  generation <= generation + ONE;
                  remaining  <= remaining - ONE;
                  if (remaining == ONE) begin
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/conway_engine.md
CONWAY_ENGINE -- requirements
Module: conway_engine

Interface
REQ-001 Parameters: WIDTH, default 32, grid columns (>=3).
REQ-002 Parameters: HEIGHT, default 32, grid rows (>=3).
REQ-003 Parameters: WRAP, default 0; 0 = cells outside the grid count as dead, 1 = toroidal neighbourhood.
REQ-004 Parameters: GEN_W, default 16, width of the step-count and generation counters.
REQ-005 Port: clk, in, 1, the single clock; all state updates on its rising edge.
REQ-006 Port: rst_n, in, 1, reset, asynchronous and active-low.
REQ-007 Port: load_valid, in, 1, a board-load request.
REQ-008 Port: load_ready, out, 1, high when a load is accepted (IDLE).
REQ-009 Port: load_states, in, WIDTH*HEIGHT, the board to load; bit r*WIDTH+c is cell (r,c).
REQ-010 Port: start_valid, in, 1, a run request.
REQ-011 Port: start_count, in, GEN_W, the number of generations to compute.
REQ-012 Port: busy, out, 1, high while in RUN.
REQ-013 Port: done, out, 1, a one-cycle run-completion pulse.
REQ-014 Port: out_states, out, WIDTH*HEIGHT, the registered current board, same bit order.
REQ-015 Port: generation, out, GEN_W, generations computed since the last load.
REQ-016 Port: stable, out, 1, high when the last run ended early because the board stopped changing.
REQ-017 Port: extinct, out, 1, combinational: high when out_states is all zero.

Function
REQ-018 The FSM SHALL have two states: IDLE and RUN; load_ready = (state==IDLE), busy = (state==RUN).
REQ-019 In IDLE with load_valid=1:
- out_states <= load_states;
- generation <= 0;
- stable <= 0;
- any start_valid in the same cycle is ignored (load priority).
REQ-020 In IDLE with start_valid=1, load_valid=0 and start_count>0:
- remaining <= start_count;
- stable <= 0;
- state <= RUN.
REQ-021 In IDLE with start_valid=1, load_valid=0 and start_count==0:
- state stays IDLE;
- board and generation unchanged;
- stable <= 0;
- done pulses in the next cycle.
REQ-022 Next-state per cell: survive if alive with 2 or 3 live neighbours; born if dead with exactly 3; otherwise dead. The neighbour sum SHALL be 4 bits wide (max 8).
REQ-023 Every cell, including edge and corner cells, SHALL be evaluated; neighbours follow REQ-003 (WRAP=1 indices taken mod WIDTH and mod HEIGHT).
REQ-024 Each RUN cycle where next != current:
- out_states <= next;
- generation <= generation+1 (wraps mod 2^GEN_W);
- remaining <= remaining-1.
REQ-025 When remaining==1 and that update occurs, state SHALL go to IDLE and done SHALL be high in the following cycle; n generations therefore take exactly n RUN cycles.
REQ-026 In RUN, if next == current:
- board and generation SHALL be left unchanged;
- stable <= 1;
- state <= IDLE;
- done pulses next cycle.
This includes the extinct board.
REQ-027 load_valid and start_valid SHALL be ignored in RUN; there is no abort input.
REQ-028 done SHALL be high for exactly one cycle per accepted start and never otherwise.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE;
- out_states=0, generation=0, remaining=0;
- done=0, stable=0.
REQ-030 A reset asserted mid-run SHALL abandon the run with no done pulse; after release the block is in IDLE with an empty board (extinct=1).

Verification
REQ-031 5x5, WRAP=0: load a horizontal blinker on row 2, cols 1-3, start_count=2 -> busy for 2 cycles; out_states equal to the load; generation=2; done one pulse; stable=0.
REQ-032 8x8, WRAP=1: load a glider, start_count=32 -> after 32 RUN cycles out_states equals the original load; generation=32.
REQ-033 4x4, WRAP=1: load cells (0,0),(0,3),(3,0), start_count=1 -> (3,3) born and the three corners survive; with WRAP=0 the same load gives an all-zero board.
REQ-034 Load a 2x2 block still life, start_count=100 -> done after 1 RUN cycle; stable=1; generation=0; board unchanged.
REQ-035 Load and start in the same IDLE cycle -> board loaded, no RUN, no done; next, start_count=0 -> done one cycle later, busy never high.
REQ-036 Assert rst_n=0 mid-run (remaining=5) -> outputs clear immediately with no done pulse; after release, load_ready=1 and extinct=1.
